// File: rtl/axi4_duth_noc_pkg.sv
// Shared NoC helpers: parameter-time max and a minimum-one-bit ceil(log2).
package axi4_duth_noc_pkg;

  function automatic int get_max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Index width that never collapses to zero bits for single-entry buffers.
  function automatic int log2c(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ser_shared_gen.sv
// Two-ratio serializer: latches a parallel word, then emits it LSB chunk first
// as SER_WIDTH-bit chunks on a ready/valid link.
module ser_shared_gen
  import axi4_duth_noc_pkg::*;
#(
  parameter int SER_WIDTH = 16,
  parameter int COUNT_0   = 2,
  parameter int COUNT_1   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           count_sel,
  input  logic [SER_WIDTH*COUNT_0-1:0]   parallel_in_0,
  input  logic [SER_WIDTH*COUNT_1-1:0]   parallel_in_1,
  input  logic                           valid_in,
  output logic                           ready_out,
  output logic [SER_WIDTH-1:0]           serial_out,
  output logic                           valid_out,
  input  logic                           ready_in
);

  localparam int COUNT_MAX = get_max2(COUNT_0, COUNT_1);
  localparam int CW        = log2c(COUNT_MAX);

  localparam logic EMPTY   = 1'b0;
  localparam logic SENDING = 1'b1;

  logic                 busy_q, busy_d;
  logic                 sel_q, sel_d;
  logic [CW-1:0]        idx_q, idx_d;
  logic [SER_WIDTH-1:0] buf_q [COUNT_MAX];

  logic last;
  logic accept;
  logic send;

  assign last      = (busy_q == SENDING) &&
                     (idx_q == (sel_q ? CW'(COUNT_1 - 1) : CW'(COUNT_0 - 1)));
  assign ready_out = (busy_q == EMPTY) | (last & ready_in);
  assign valid_out = busy_q;
  assign accept    = valid_in & ready_out;
  assign send      = busy_q & ready_in;

  if (COUNT_MAX == 1) begin : g_out_single
    assign serial_out = buf_q[0];
  end else begin : g_out_multi
    assign serial_out = buf_q[idx_q];
  end

  // A reload on the last chunk takes priority over going idle.
  always_comb begin
    busy_d = busy_q;
    sel_d  = sel_q;
    idx_d  = idx_q;
    if (accept) begin
      busy_d = SENDING;
      sel_d  = count_sel;
      idx_d  = '0;
    end else if (send) begin
      if (last) begin
        busy_d = EMPTY;
      end else begin
        idx_d = idx_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= EMPTY;
      sel_q  <= 1'b0;
      idx_q  <= '0;
    end else begin
      busy_q <= busy_d;
      sel_q  <= sel_d;
      idx_q  <= idx_d;
    end
  end

  // Entries beyond the selected ratio simply hold their previous contents.
  for (genvar k = 0; k < COUNT_MAX; k++) begin : g_buf
    logic [SER_WIDTH-1:0] chunk0;
    logic [SER_WIDTH-1:0] chunk1;

    if (k < COUNT_0) begin : g_c0
      assign chunk0 = parallel_in_0[k*SER_WIDTH +: SER_WIDTH];
    end else begin : g_c0_hold
      assign chunk0 = buf_q[k];
    end

    if (k < COUNT_1) begin : g_c1
      assign chunk1 = parallel_in_1[k*SER_WIDTH +: SER_WIDTH];
    end else begin : g_c1_hold
      assign chunk1 = buf_q[k];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        buf_q[k] <= '0;
      end else if (accept) begin
        buf_q[k] <= count_sel ? chunk1 : chunk0;
      end
    end
  end

endmodule

// File: tb/tb_ser_shared_gen.sv
// Directed and randomized-stall bench for ser_shared_gen (SER_WIDTH=16, ratios 4/2).
module tb_ser_shared_gen;

  localparam int SW = 16;
  localparam int C0 = 4;
  localparam int C1 = 2;

  logic            clk;
  logic            rst;
  logic            count_sel;
  logic [SW*C0-1:0] parallel_in_0;
  logic [SW*C1-1:0] parallel_in_1;
  logic            valid_in;
  logic            ready_out;
  logic [SW-1:0]   serial_out;
  logic            valid_out;
  logic            ready_in;

  int checks = 0;
  int errors = 0;

  ser_shared_gen #(.SER_WIDTH(SW), .COUNT_0(C0), .COUNT_1(C1)) dut (
    .clk          (clk),
    .rst          (rst),
    .count_sel    (count_sel),
    .parallel_in_0(parallel_in_0),
    .parallel_in_1(parallel_in_1),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .serial_out   (serial_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic chk_out(input string name, input logic [SW-1:0] ser,
                         input logic vld, input logic rdy);
    checks++;
    if ({serial_out, valid_out, ready_out} !== {ser, vld, rdy}) begin
      errors++;
      $display("FAIL %s: serial_out=%h valid_out=%b ready_out=%b, expected %h %b %b",
               name, serial_out, valid_out, ready_out, ser, vld, rdy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; valid_in = 1'b0; ready_in = 1'b1; count_sel = 1'b0;
    parallel_in_0 = '0; parallel_in_1 = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (valid_out !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", valid_out);
    end
    checks++;
    if (ready_out !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", ready_out);
    end
    checks++;
    if (serial_out !== 16'h0000) begin
      errors++; $display("FAIL reset_serial: got %h expected 0000", serial_out);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_ratio0();
    @(negedge clk);
    count_sel = 1'b0; parallel_in_0 = 64'h4444_3333_2222_1111;
    valid_in = 1'b1; ready_in = 1'b1;
    #1 chk_out("r0_idle", 16'h0000, 1'b0, 1'b1);
    @(negedge clk); valid_in = 1'b0;
    #1 chk_out("r0_c0", 16'h1111, 1'b1, 1'b0);
    @(negedge clk); #1 chk_out("r0_c1", 16'h2222, 1'b1, 1'b0);
    @(negedge clk); #1 chk_out("r0_c2", 16'h3333, 1'b1, 1'b0);
    @(negedge clk); #1 chk_out("r0_c3", 16'h4444, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    checks++;
    if (valid_out !== 1'b0) begin
      errors++; $display("FAIL r0_done: valid_out=%b expected 0", valid_out);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    count_sel = 1'b1; parallel_in_1 = 32'hBBBB_AAAA; valid_in = 1'b1; ready_in = 1'b1;
    @(negedge clk); parallel_in_1 = 32'hDDDD_CCCC;
    #1 chk_out("b2b_aaaa", 16'hAAAA, 1'b1, 1'b0);
    @(negedge clk); #1 chk_out("b2b_bbbb", 16'hBBBB, 1'b1, 1'b1);
    @(negedge clk); valid_in = 1'b0;
    #1 chk_out("b2b_cccc", 16'hCCCC, 1'b1, 1'b0);
    @(negedge clk); #1 chk_out("b2b_dddd", 16'hDDDD, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    checks++;
    if (valid_out !== 1'b0) begin
      errors++; $display("FAIL b2b_done: valid_out=%b expected 0", valid_out);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    count_sel = 1'b0; parallel_in_0 = 64'h4444_3333_2222_1111;
    valid_in = 1'b1; ready_in = 1'b1;
    @(negedge clk); valid_in = 1'b0;
    #1 chk_out("bp_c0", 16'h1111, 1'b1, 1'b0);
    @(negedge clk); ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk_out("bp_hold", 16'h2222, 1'b1, 1'b0);
      @(negedge clk);
    end
    ready_in = 1'b1;
    #1 chk_out("bp_c1", 16'h2222, 1'b1, 1'b0);
    @(negedge clk); #1 chk_out("bp_c2", 16'h3333, 1'b1, 1'b0);
    @(negedge clk); #1 chk_out("bp_c3", 16'h4444, 1'b1, 1'b1);
    @(negedge clk);
  endtask

  task automatic test_sel_change();
    @(negedge clk);
    count_sel = 1'b0; parallel_in_0 = 64'hA004_A003_A002_A001;
    valid_in = 1'b1; ready_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0; count_sel = 1'b1;
    parallel_in_0 = 64'hFFFF_FFFF_FFFF_FFFF; parallel_in_1 = 32'hEEEE_EEEE;
    #1 chk_out("sel_c0", 16'hA001, 1'b1, 1'b0);
    @(negedge clk); #1 chk_out("sel_c1", 16'hA002, 1'b1, 1'b0);
    @(negedge clk); #1 chk_out("sel_c2", 16'hA003, 1'b1, 1'b0);
    @(negedge clk);
    valid_in = 1'b1; parallel_in_1 = 32'h8888_7777;
    #1 chk_out("sel_c3", 16'hA004, 1'b1, 1'b1);
    @(negedge clk); valid_in = 1'b0;
    #1 chk_out("sel_new0", 16'h7777, 1'b1, 1'b0);
    @(negedge clk); #1 chk_out("sel_new1", 16'h8888, 1'b1, 1'b1);
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    count_sel = 1'b0; parallel_in_0 = 64'h4444_3333_2222_1111;
    valid_in = 1'b1; ready_in = 1'b1;
    @(negedge clk); valid_in = 1'b0;
    #1 chk_out("mr_c0", 16'h1111, 1'b1, 1'b0);
    @(negedge clk); #1 chk_out("mr_c1", 16'h2222, 1'b1, 1'b0);
    #1 rst = 1'b0;
    #1 chk_out("mr_async", 16'h0000, 1'b0, 1'b1);
    @(negedge clk); rst = 1'b1;
    #1 chk_out("mr_idle", 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    count_sel = 1'b1; parallel_in_1 = 32'h6666_5555; valid_in = 1'b1;
    @(negedge clk); valid_in = 1'b0;
    #1 chk_out("mr_new0", 16'h5555, 1'b1, 1'b0);
    @(negedge clk); #1 chk_out("mr_new1", 16'h6666, 1'b1, 1'b1);
    @(negedge clk);
  endtask

  // Reassembles chunks against a queue of accepted words, like a paired deserializer.
  task automatic test_loopback();
    logic [63:0] exp_q[$];
    logic        sel_q[$];
    logic [63:0] w;
    int issued = 0, done = 0, idx = 0, cycles = 0;
    logic acc_prev = 1'b0;
    logic acc, snd;
    valid_in = 1'b0;
    while (done < 1000 && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      if (acc_prev) valid_in = 1'b0;
      if (!valid_in && issued < 1000 && $urandom_range(3) != 0) begin
        valid_in = 1'b1;
        count_sel = 1'($urandom_range(1));
        parallel_in_0 = {$urandom, $urandom};
        parallel_in_1 = $urandom;
      end
      ready_in = ($urandom_range(3) != 0);
      #1;
      acc = valid_in & ready_out;
      snd = valid_out & ready_in;
      if (snd) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL lb_spurious: chunk %h sent with no word outstanding", serial_out);
        end else begin
          w = exp_q[0];
          if (serial_out !== w[idx*SW +: SW]) begin
            errors++;
            $display("FAIL lb_chunk: word %0d chunk %0d got %h expected %h",
                     done, idx, serial_out, w[idx*SW +: SW]);
          end
          idx++;
          if (idx == (sel_q[0] ? C1 : C0)) begin
            void'(exp_q.pop_front());
            void'(sel_q.pop_front());
            idx = 0;
            done++;
          end
        end
      end
      if (acc) begin
        exp_q.push_back(count_sel ? {32'h0, parallel_in_1} : parallel_in_0);
        sel_q.push_back(count_sel);
        issued++;
      end
      acc_prev = acc;
    end
    checks++;
    if (done != 1000) begin
      errors++;
      $display("FAIL lb_timeout: words completed %0d expected 1000", done);
    end
    @(negedge clk);
    valid_in = 1'b0; ready_in = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ratio0();
    test_back_to_back();
    test_backpressure();
    test_sel_change();
    test_mid_reset();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
